// File: rtl/uart_pkg.sv
// Shared UART RX definitions: parity mode encoding and frame-length limits.
package uart_pkg;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } par_mode_e;

    localparam int unsigned DATA_LEN_MIN = 5;

endpackage

// File: rtl/uart_err_sat_cnt.sv
// Saturating error counter with synchronous clear; a clear coinciding with
// an increment leaves the count at one so the new event is not lost.
module uart_err_sat_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? CNT_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_parity_checker.sv
// UART RX parity checker: two-stage pipeline from strobe to PAR_VLD/PAR_ERR,
// plus saturating error count and sticky error flag for the register file.
module uart_rx_parity_checker
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         PAR_CHK_EN,
    input  logic [DATA_W-1:0]            P_DATA,
    input  logic [$clog2(DATA_W+1)-1:0]  DATA_LEN,
    input  logic [2:0]                   PAR_MODE,
    input  logic                         SAMPLED_BIT,
    input  logic                         CNT_CLR,
    output logic                         PAR_VLD,
    output logic                         PAR_ERR,
    output logic                         ERR_STICKY,
    output logic [CNT_W-1:0]             ERR_CNT
);

    localparam int unsigned LEN_W = $clog2(DATA_W + 1);

    logic [LEN_W-1:0]  len_eff;
    logic [DATA_W-1:0] mask;
    logic              data_par;
    logic              exp_bit;
    logic              chk;

    logic s1_vld;
    logic s1_exp;
    logic s1_smp;
    logic s1_chk;

    // Out-of-range lengths are clamped rather than rejected.
    always_comb begin
        len_eff = DATA_LEN;
        if (DATA_LEN > LEN_W'(DATA_W)) begin
            len_eff = LEN_W'(DATA_W);
        end else if (DATA_LEN < LEN_W'(DATA_LEN_MIN)) begin
            len_eff = LEN_W'(DATA_LEN_MIN);
        end
        mask = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            mask[i] = (LEN_W'(i) < len_eff);
        end
        data_par = ^(P_DATA & mask);
        exp_bit  = 1'b0;
        chk      = 1'b1;
        case (PAR_MODE)
            PAR_EVEN:  exp_bit = data_par;
            PAR_ODD:   exp_bit = ~data_par;
            PAR_MARK:  exp_bit = 1'b1;
            PAR_SPACE: exp_bit = 1'b0;
            default:   chk     = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_vld  <= 1'b0;
            s1_exp  <= 1'b0;
            s1_smp  <= 1'b0;
            s1_chk  <= 1'b0;
            PAR_VLD <= 1'b0;
            PAR_ERR <= 1'b0;
        end else begin
            s1_vld <= PAR_CHK_EN;
            if (PAR_CHK_EN) begin
                s1_exp <= exp_bit;
                s1_smp <= SAMPLED_BIT;
                s1_chk <= chk;
            end
            PAR_VLD <= s1_vld;
            PAR_ERR <= s1_vld & s1_chk & (s1_exp != s1_smp);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ERR_STICKY <= 1'b0;
        end else if (CNT_CLR) begin
            ERR_STICKY <= PAR_ERR;
        end else if (PAR_ERR) begin
            ERR_STICKY <= 1'b1;
        end
    end

    uart_err_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .CLK (CLK),
        .RST (RST),
        .inc (PAR_ERR),
        .clr (CNT_CLR),
        .cnt (ERR_CNT)
    );

endmodule

// File: tb/tb_uart_rx_parity_checker.sv
// Bench for uart_rx_parity_checker: per-cycle comparison against a
// frame-level model, with directed literal checks and random traffic.
module tb_uart_rx_parity_checker;
    import uart_pkg::*;

    localparam int MAXC = 4200;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PAR_CHK_EN = 1'b0;
    logic [7:0] P_DATA = '0;
    logic [3:0] DATA_LEN = 4'd8;
    logic [2:0] PAR_MODE = '0;
    logic       SAMPLED_BIT = 1'b0;
    logic       CNT_CLR = 1'b0;

    logic       PAR_VLD, PAR_ERR, ERR_STICKY;
    logic [7:0] ERR_CNT;
    logic       PAR_VLD2, PAR_ERR2, ERR_STICKY2;
    logic [1:0] ERR_CNT2;

    uart_rx_parity_checker #(.DATA_W(8), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .PAR_CHK_EN(PAR_CHK_EN), .P_DATA(P_DATA),
        .DATA_LEN(DATA_LEN), .PAR_MODE(PAR_MODE), .SAMPLED_BIT(SAMPLED_BIT),
        .CNT_CLR(CNT_CLR), .PAR_VLD(PAR_VLD), .PAR_ERR(PAR_ERR),
        .ERR_STICKY(ERR_STICKY), .ERR_CNT(ERR_CNT)
    );

    uart_rx_parity_checker #(.DATA_W(8), .CNT_W(2)) dut2 (
        .CLK(CLK), .RST(RST), .PAR_CHK_EN(PAR_CHK_EN), .P_DATA(P_DATA),
        .DATA_LEN(DATA_LEN), .PAR_MODE(PAR_MODE), .SAMPLED_BIT(SAMPLED_BIT),
        .CNT_CLR(CNT_CLR), .PAR_VLD(PAR_VLD2), .PAR_ERR(PAR_ERR2),
        .ERR_STICKY(ERR_STICKY2), .ERR_CNT(ERR_CNT2)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    bit vld_at [MAXC];
    bit err_at [MAXC];
    bit clr_at [MAXC];
    bit rst_at [MAXC];

    int checks = 0;
    int errors = 0;
    bit started = 0;
    int mc = 0;
    int mc2 = 0;
    bit ms = 0;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Expected parity error for one frame, straight from the mode rules.
    function automatic bit model_err(logic [2:0] mode, logic [3:0] len, logic [7:0] d, bit smp);
        int l;
        int ones;
        bit x;
        l = int'(len);
        if (l > 8) l = 8;
        if (l < 5) l = 5;
        ones = 0;
        for (int i = 0; i < l; i++) ones += int'(d[i]);
        x = bit'(ones % 2);
        case (mode)
            3'd1:    return x != smp;
            3'd2:    return (!x) != smp;
            3'd3:    return smp != 1'b1;
            3'd4:    return smp != 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(bit stb, logic [2:0] mode, logic [3:0] len, logic [7:0] d,
                         bit smp, bit clr, bit rst);
        @(posedge CLK);
        #1;
        PAR_CHK_EN  = stb;
        PAR_MODE    = mode;
        DATA_LEN    = len;
        P_DATA      = d;
        SAMPLED_BIT = smp;
        CNT_CLR     = clr;
        RST         = rst;
        if (cyc + 2 < MAXC) begin
            clr_at[cyc] = clr;
            rst_at[cyc] = rst;
            if (stb) begin
                vld_at[cyc+2] = 1'b1;
                err_at[cyc+2] = model_err(mode, len, d, smp);
            end
        end
        started = 1'b1;
    endtask

    task automatic frame(logic [2:0] mode, logic [3:0] len, logic [7:0] d, bit smp);
        drive(1'b1, mode, len, d, smp, 1'b0, 1'b0);
    endtask

    task automatic idle(bit clr);
        drive(1'b0, 3'd0, 4'd8, 8'h00, 1'b0, clr, 1'b0);
    endtask

    // Model: outputs scheduled two cycles after each strobe, counters follow
    // the PAR_ERR seen in the previous cycle.
    always @(negedge CLK) begin
        if (started && cyc > 0 && cyc < MAXC) begin
            if (rst_at[cyc] || rst_at[cyc-1]) begin
                mc = 0;
                mc2 = 0;
                ms = 0;
                vld_at[cyc] = 1'b0;
                err_at[cyc] = 1'b0;
            end else if (clr_at[cyc-1]) begin
                mc  = int'(err_at[cyc-1]);
                mc2 = int'(err_at[cyc-1]);
                ms  = err_at[cyc-1];
            end else if (err_at[cyc-1]) begin
                if (mc < 255) mc++;
                if (mc2 < 3) mc2++;
                ms = 1'b1;
            end
            check("PAR_VLD", int'(PAR_VLD), int'(vld_at[cyc]));
            check("PAR_ERR", int'(PAR_ERR), int'(err_at[cyc]));
            check("ERR_CNT", int'(ERR_CNT), mc);
            check("ERR_STICKY", int'(ERR_STICKY), int'(ms));
            check("ERR_CNT_W2", int'(ERR_CNT2), mc2);
            check("PAR_VLD_W2", int'(PAR_VLD2), int'(vld_at[cyc]));
        end
    end

    initial begin
        repeat (3) drive(1'b0, 3'd0, 4'd8, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge CLK);
        check("reset_cnt", int'(ERR_CNT), 0);
        check("reset_vld", int'(PAR_VLD), 0);

        // Even, len 8, A5 has four ones -> expected 0, sampled 0: no error.
        frame(3'd1, 4'd8, 8'hA5, 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge CLK);
        check("even_vld", int'(PAR_VLD), 1);
        check("even_err", int'(PAR_ERR), 0);

        // Odd, len 7, 81 -> bit7 masked, one '1', expected 0, sampled 1: error.
        frame(3'd2, 4'd7, 8'h81, 1'b1);
        idle(1'b0);
        idle(1'b0);
        @(negedge CLK);
        check("odd_err", int'(PAR_ERR), 1);
        idle(1'b0);
        @(negedge CLK);
        check("odd_cnt", int'(ERR_CNT), 1);
        check("odd_sticky", int'(ERR_STICKY), 1);

        // Mark/space back-to-back, sampled 0: only mark frames err.
        frame(3'd3, 4'd8, 8'h3C, 1'b0);
        frame(3'd4, 4'd8, 8'h3C, 1'b0);
        frame(3'd3, 4'd8, 8'h3C, 1'b0);
        @(negedge CLK);
        check("ms0_vld", int'(PAR_VLD), 1);
        check("ms0_err", int'(PAR_ERR), 1);
        frame(3'd4, 4'd8, 8'h3C, 1'b0);
        @(negedge CLK);
        check("ms1_err", int'(PAR_ERR), 0);
        idle(1'b0);
        @(negedge CLK);
        check("ms2_err", int'(PAR_ERR), 1);
        idle(1'b0);
        @(negedge CLK);
        check("ms3_vld", int'(PAR_VLD), 1);
        check("ms3_err", int'(PAR_ERR), 0);
        idle(1'b0);
        idle(1'b0);
        @(negedge CLK);
        check("ms_cnt", int'(ERR_CNT), 3);

        // Three more errors: narrow counter must hold at 3.
        repeat (3) frame(3'd3, 4'd5, 8'hFF, 1'b0);
        repeat (3) idle(1'b0);
        @(negedge CLK);
        check("sat_cnt8", int'(ERR_CNT), 6);
        check("sat_cnt2", int'(ERR_CNT2), 3);

        // Clear coincident with an error increment keeps that error.
        frame(3'd3, 4'd8, 8'h00, 1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        @(negedge CLK);
        check("clrinc_cnt8", int'(ERR_CNT), 1);
        check("clrinc_cnt2", int'(ERR_CNT2), 1);
        check("clrinc_sticky", int'(ERR_STICKY), 1);
        idle(1'b1);
        idle(1'b0);
        @(negedge CLK);
        check("clr_cnt", int'(ERR_CNT), 0);
        check("clr_sticky", int'(ERR_STICKY), 0);

        // Mode none and reserved mode 6 never flag errors.
        frame(3'd0, 4'd8, 8'h01, 1'b1);
        frame(3'd6, 4'd8, 8'h01, 1'b0);
        frame(3'd0, 4'd8, 8'h01, 1'b0);
        @(negedge CLK);
        check("none_vld", int'(PAR_VLD), 1);
        check("none_err", int'(PAR_ERR), 0);
        frame(3'd6, 4'd8, 8'h00, 1'b1);
        repeat (3) idle(1'b0);
        @(negedge CLK);
        check("none_cnt", int'(ERR_CNT), 0);

        // Reset one cycle after an errored strobe discards it.
        frame(3'd1, 4'd8, 8'h01, 1'b1);
        repeat (2) idle(1'b0);
        frame(3'd3, 4'd8, 8'h00, 1'b0);
        drive(1'b0, 3'd0, 4'd8, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        @(negedge CLK);
        check("rst_vld", int'(PAR_VLD), 0);
        check("rst_cnt", int'(ERR_CNT), 0);
        frame(3'd2, 4'd8, 8'h03, 1'b0);
        idle(1'b0);
        idle(1'b0);
        @(negedge CLK);
        check("post_rst_vld", int'(PAR_VLD), 1);
        check("post_rst_err", int'(PAR_ERR), 1);

        // Random traffic, including out-of-range lengths, clears and resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive(1'b0, 3'd0, 4'd8, 8'h00, 1'b0, 1'b0, 1'b1);
            end else begin
                drive($urandom_range(0, 9) < 7,
                      3'($urandom_range(0, 7)),
                      4'($urandom_range(0, 15)),
                      8'($urandom),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 29) == 0,
                      1'b0);
            end
        end
        repeat (4) idle(1'b0);
        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
